// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        FLD_TAG  = 2'd0,
        FLD_IDX  = 2'd1,
        FLD_WORD = 2'd2
    } field_t;

    function automatic int off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int words_per_line, input int num_lines);
        return 30 - off_w(words_per_line) - idx_w(num_lines);
    endfunction

    // Result is right-aligned; the caller casts it down to the field width.
    function automatic logic [31:0] addr_field(input logic [31:0] pc, input field_t fld,
                                               input int ow, input int iw);
        logic [31:0] wa;
        logic [31:0] res;
        wa = pc >> 2;
        case (fld)
            FLD_WORD: res = wa & ((32'd1 << ow) - 32'd1);
            FLD_IDX:  res = (wa >> ow) & ((32'd1 << iw) - 32'd1);
            default:  res = wa >> (ow + iw);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the cache: combinational indexed read, one-word write port,
// line validate with tag write, and flush-all (flush wins over validate).
module icache_line_store
    import icache_pkg::*;
#(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int OFF_W          = off_w(WORDS_PER_LINE),
    parameter int IDX_W          = idx_w(NUM_LINES),
    parameter int TAG_W          = tag_w(WORDS_PER_LINE, NUM_LINES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_word,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_data,
    input  logic             set_valid,
    input  logic [TAG_W-1:0] set_tag
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [TAG_W-1:0]     tag_d  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];
    logic [31:0]          data_d [NUM_LINES][WORDS_PER_LINE];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            data_d[wr_idx][wr_off] = wr_data;
        end
        if (set_valid) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = set_tag;
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents are meaningless until validated, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: same-cycle hits, word-by-word line refill
// from main memory on a miss, and saturating hit/miss counters.
//   state  | meaning
//   IDLE   | lookup; hit returns Inst, miss latches line base and starts refill
//   REFILL | reads line words from main memory, stalls fetch until line is valid
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int MM_LATENCY     = 1,
    parameter int CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      PC,
    input  logic             Req,
    input  logic             Flush,
    output logic [31:0]      Inst,
    output logic             Stall,
    output logic [31:0]      MM_Addr,
    output logic             Access_MM,
    input  logic [31:0]      Data_MM,
    output logic [CNT_W-1:0] Hit_Cnt,
    output logic [CNT_W-1:0] Miss_Cnt
);

    localparam int OFF_W  = off_w(WORDS_PER_LINE);
    localparam int IDX_W  = idx_w(NUM_LINES);
    localparam int TAG_W  = tag_w(WORDS_PER_LINE, NUM_LINES);
    localparam int BASE_W = TAG_W + IDX_W;
    localparam int LAT_W  = (MM_LATENCY > 1) ? $clog2(MM_LATENCY) : 1;

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MM_LATENCY - 1);
    localparam logic [OFF_W-1:0] W_LAST   = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            state_q, state_d;
    logic [BASE_W-1:0] base_q, base_d;
    logic [OFF_W-1:0]  w_q, w_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [31:0]       mm_addr_q, mm_addr_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]  pc_idx;
    logic [OFF_W-1:0]  pc_off;
    logic [TAG_W-1:0]  pc_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_word;
    logic              hit;
    logic [31:0]       refill_addr;
    logic              wr_en, set_valid, stall, access;
    logic [31:0]       inst;

    assign pc_idx      = IDX_W'(addr_field(PC, FLD_IDX, OFF_W, IDX_W));
    assign pc_off      = OFF_W'(addr_field(PC, FLD_WORD, OFF_W, IDX_W));
    assign pc_tag      = TAG_W'(addr_field(PC, FLD_TAG, OFF_W, IDX_W));
    assign hit         = rd_valid && (rd_tag == pc_tag);
    assign refill_addr = {base_q, w_q, 2'b00};

    icache_line_store #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .OFF_W          (OFF_W),
        .IDX_W          (IDX_W),
        .TAG_W          (TAG_W)
    ) u_store (
        .clk       (CLK),
        .rst_n     (RESET),
        .flush     (Flush),
        .rd_idx    (pc_idx),
        .rd_off    (pc_off),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word   (rd_word),
        .wr_en     (wr_en),
        .wr_idx    (base_q[IDX_W-1:0]),
        .wr_off    (w_q),
        .wr_data   (Data_MM),
        .set_valid (set_valid),
        .set_tag   (base_q[BASE_W-1:IDX_W])
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        w_d        = w_q;
        lat_d      = lat_q;
        mm_addr_d  = mm_addr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        stall      = 1'b0;
        access     = 1'b0;
        inst       = '0;
        wr_en      = 1'b0;
        set_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Req) begin
                    if (hit) begin
                        inst = rd_word;
                        if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end else begin
                        stall = 1'b1;
                        if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                        base_d  = PC[31:OFF_W+2];
                        w_d     = '0;
                        lat_d   = '0;
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                stall     = 1'b1;
                access    = 1'b1;
                mm_addr_d = refill_addr;
                if (lat_q == LAT_LAST) begin
                    wr_en = 1'b1;
                    lat_d = '0;
                    w_d   = w_q + OFF_W'(1);
                    if (w_q == W_LAST) begin
                        set_valid = !Flush;
                        state_d   = IDLE;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
                if (Flush) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            base_q     <= '0;
            w_q        <= '0;
            lat_q      <= '0;
            mm_addr_q  <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            w_q        <= w_d;
            lat_q      <= lat_d;
            mm_addr_q  <= mm_addr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // The lookup path is combinational from PC/Req, so gate it while reset is held.
    assign Inst      = RESET ? inst : '0;
    assign Stall     = RESET ? stall : 1'b0;
    assign Access_MM = access;
    assign MM_Addr   = (state_q == REFILL) ? refill_addr : mm_addr_q;
    assign Hit_Cnt   = hit_cnt_q;
    assign Miss_Cnt  = miss_cnt_q;

endmodule
